ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of simultaneously held keys tracked (1..16).
REQ-002 Parameter TIMEOUT_CYC, default 50000: clock cycles allowed between a prefix byte and the next byte.
REQ-003 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 clr  in  1  synchronous, active-high; empties the held-key table.
REQ-006 ps2_key_data  in  8  received PS/2 byte.
REQ-007 ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid when it is high.
REQ-008 ev_valid  out  1  one-cycle pulse marking a decoded key event.
REQ-009 ev_code  out  9  event code; bit 8 = E0-extended, bits 7:0 = scan code.
REQ-010 ev_make  out  1  1 = press, 0 = release; valid with ev_valid.
REQ-011 held_codes  out  9*NUM_SLOTS  slot i occupies bits [9i+8:9i].
REQ-012 held_valid  out  NUM_SLOTS  bit i set = slot i holds a key.
REQ-013 held_count  out  $clog2(NUM_SLOTS+1)  number of set held_valid bits.
REQ-014 overflow  out  1  sticky; a make arrived while the table was full.
REQ-015 HEX0, HEX1, HEX2  out  7 each  active-low segments showing the last ev_code.

Function
REQ-016 Decoder FSM SHALL have states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-017 IDLE: E0->EXT; F0->BRK; FA/AA/EE/FE/00/FF SHALL be discarded; any other byte SHALL emit make {0,byte}.
REQ-018 EXT: F0->EXT_BRK; E0 stays in EXT; any other byte emits make {1,byte} and returns to IDLE.
REQ-019 BRK emits break {0,byte}; EXT_BRK emits break {1,byte}; both return to IDLE.
REQ-020 ev_valid SHALL assert exactly one cycle after the strobe of the final byte, with ev_code and ev_make valid in that cycle.
REQ-021 In any non-IDLE state, TIMEOUT_CYC cycles without a strobe SHALL return the FSM to IDLE with no event.
REQ-022 A make for a code already held SHALL produce no event and no table change (typematic suppression).
REQ-023 A make for a new code SHALL occupy the lowest-index free slot on the same edge that raises ev_valid.
REQ-024 A make with the table full SHALL produce no event and SHALL set overflow.
REQ-025 A break SHALL clear the matching slot without compacting the others and SHALL emit an event.
REQ-026 A break for an unheld code SHALL still emit an event and SHALL leave the table unchanged.
REQ-027 clr together with a strobe SHALL empty the table and clear overflow; that byte is still decoded but SHALL NOT update the table.
REQ-028 held_count SHALL always equal the popcount of held_valid.

Reset
REQ-029 While resetn is low: FSM = IDLE, ev_valid = 0, ev_code = 0, ev_make = 0, held_valid = 0, held_codes = 0, held_count = 0, overflow = 0, timeout counter = 0.
REQ-030 HEX0..HEX2 SHALL display 000 in reset; a prefix byte received before reset SHALL be forgotten.

Configuration
REQ-031 Macro PS2_TRACKER_HEX_EN defined: HEX0/HEX1 show ev_code[3:0]/[7:4] and HEX2 shows ev_code[8], updated on each ev_valid.
REQ-032 Macro undefined: no display logic; HEX0..HEX2 SHALL be tied to 7'h7F (blank).

Structure
REQ-033 Package ps2_pkg SHALL hold the FSM state enum, the prefix constants E0 and F0, the discard-byte list and the 9-bit key-code typedef.
REQ-034 Segment decoding SHALL reuse the existing Hexadecimal_To_Seven_Segment module; the table SHALL be a sub-module ps2_key_table (lookup, allocate, free, count).

Verification
REQ-035 Bytes 1C -> ev make 01C one cycle later; slot0 = 01C; held_count = 1.
REQ-036 Bytes E0 75, then E0 F0 75 -> make 175, then break 175; held_valid = 0.
REQ-037 Bytes 1C 1C 1C (typematic) -> exactly one event; held_count = 1.
REQ-038 NUM_SLOTS=4; makes 15 1D 24 2D 2C -> four events; overflow = 1; 2C not held; break 1D frees slot1, a following make 2C fills slot1.
REQ-039 Byte E0, then 50000 idle cycles, then 1C -> make 01C (not 11C).
REQ-040 Make 1C, then resetn low mid-sequence after F0, release, then byte 1C -> make 01C; no break event; table and overflow cleared.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker: decoder states,
// prefix bytes, bytes the decoder ignores, and the 9-bit key-code type.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } dec_state_e;

    typedef logic [8:0] key_code_t;

    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    // Keyboard status/ack bytes that carry no key information.
    localparam int NUM_DISCARD = 6;
    localparam logic [8*NUM_DISCARD-1:0] DISCARD_BYTES =
        {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_DISCARD; i++) begin
            if (DISCARD_BYTES[8*i +: 8] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/Hexadecimal_To_Seven_Segment.sv
// Hex digit to active-low seven-segment pattern (bit order gfedcba).
module Hexadecimal_To_Seven_Segment (
    input  logic [3:0] hex_number,
    output logic [6:0] seven_seg_display
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seven_seg_display = 7'h7F;
        case (hex_number)
            4'h0: seven_seg_display = 7'h40;
            4'h1: seven_seg_display = 7'h79;
            4'h2: seven_seg_display = 7'h24;
            4'h3: seven_seg_display = 7'h30;
            4'h4: seven_seg_display = 7'h19;
            4'h5: seven_seg_display = 7'h12;
            4'h6: seven_seg_display = 7'h02;
            4'h7: seven_seg_display = 7'h78;
            4'h8: seven_seg_display = 7'h00;
            4'h9: seven_seg_display = 7'h18;
            4'hA: seven_seg_display = 7'h08;
            4'hB: seven_seg_display = 7'h03;
            4'hC: seven_seg_display = 7'h46;
            4'hD: seven_seg_display = 7'h21;
            4'hE: seven_seg_display = 7'h06;
            default: seven_seg_display = 7'h0E;
        endcase
    end

endmodule

// File: rtl/ps2_key_table.sv
// Held-key table: parallel lookup, lowest-free-slot allocation, in-place
// free (no compaction) and a combinational population count.
module ps2_key_table
    import ps2_pkg::*;
#(
    parameter int NUM_SLOTS = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic                             alloc_i,
    input  logic                             free_i,
    input  logic [8:0]                       code_i,
    output logic                             hit_o,
    output logic                             full_o,
    output logic [9*NUM_SLOTS-1:0]           held_codes_o,
    output logic [NUM_SLOTS-1:0]             held_valid_o,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   held_count_o
);

    localparam int CW = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0]   valid_q, valid_d;
    logic [9*NUM_SLOTS-1:0] codes_q, codes_d;
    logic [NUM_SLOTS-1:0]   match;
    logic [NUM_SLOTS-1:0]   alloc_sel;
    logic                   found;
    logic [CW-1:0]          count;

    // Lookup, one-hot lowest free slot, and popcount of occupied slots.
    always_comb begin
        match     = '0;
        alloc_sel = '0;
        found     = 1'b0;
        count     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = valid_q[i] && (codes_q[9*i +: 9] == code_i);
            if (!valid_q[i] && !found) begin
                alloc_sel[i] = 1'b1;
                found        = 1'b1;
            end
            count = count + CW'(valid_q[i]);
        end
    end

    // Next table contents; clear dominates any update from the same byte.
    always_comb begin
        valid_d = valid_q;
        codes_d = codes_q;
        if (clr_i) begin
            valid_d = '0;
            codes_d = '0;
        end else if (alloc_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_sel[i]) begin
                    valid_d[i]         = 1'b1;
                    codes_d[9*i +: 9]  = code_i;
                end
            end
        end else if (free_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (match[i]) begin
                    valid_d[i]         = 1'b0;
                    codes_d[9*i +: 9]  = '0;
                end
            end
        end
    end

    // Table storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            codes_q <= '0;
        end else begin
            valid_q <= valid_d;
            codes_q <= codes_d;
        end
    end

    assign hit_o        = |match;
    assign full_o       = &valid_q;
    assign held_codes_o = codes_q;
    assign held_valid_o = valid_q;
    assign held_count_o = count;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder with held-key tracking.
// Optional macro PS2_TRACKER_HEX_EN drives HEX0..HEX2 with the last event
// code; without it the displays are blanked.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                             CLOCK_50,
    input  logic                             resetn,
    input  logic                             clr,
    input  logic [7:0]                       ps2_key_data,
    input  logic                             ps2_key_pressed,
    output logic                             ev_valid,
    output logic [8:0]                       ev_code,
    output logic                             ev_make,
    output logic [9*NUM_SLOTS-1:0]           held_codes,
    output logic [NUM_SLOTS-1:0]             held_valid,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   held_count,
    output logic                             overflow,
    output logic [6:0]                       HEX0,
    output logic [6:0]                       HEX1,
    output logic [6:0]                       HEX2
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    dec_state_e state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       ev_valid_q, ev_valid_d;
    key_code_t  ev_code_q, ev_code_d;
    logic       ev_make_q, ev_make_d;
    logic       overflow_q, overflow_d;

    logic       dec_valid;
    logic       dec_make;
    key_code_t  dec_code;
    logic       tbl_hit, tbl_full, tbl_alloc, tbl_free;
    logic       emit;

    // Decoder FSM: prefix tracking, event decode, inter-byte timeout.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        dec_valid = 1'b0;
        dec_make  = 1'b0;
        dec_code  = '0;
        if (ps2_key_pressed) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (ps2_key_data == PREFIX_E0) begin
                        state_d = StExt;
                    end else if (ps2_key_data == PREFIX_F0) begin
                        state_d = StBrk;
                    end else if (!is_discard(ps2_key_data)) begin
                        dec_valid = 1'b1;
                        dec_make  = 1'b1;
                        dec_code  = {1'b0, ps2_key_data};
                    end
                end
                StExt: begin
                    if (ps2_key_data == PREFIX_F0) begin
                        state_d = StExtBrk;
                    end else if (ps2_key_data != PREFIX_E0) begin
                        dec_valid = 1'b1;
                        dec_make  = 1'b1;
                        dec_code  = {1'b1, ps2_key_data};
                        state_d   = StIdle;
                    end
                end
                StBrk: begin
                    dec_valid = 1'b1;
                    dec_code  = {1'b0, ps2_key_data};
                    state_d   = StIdle;
                end
                StExtBrk: begin
                    dec_valid = 1'b1;
                    dec_code  = {1'b1, ps2_key_data};
                    state_d   = StIdle;
                end
            endcase
        end else if (state_q != StIdle) begin
            if (tmo_q == TIMEOUT_LAST) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // Event filtering against the table and sticky overflow.
    always_comb begin
        tbl_alloc  = dec_valid && dec_make && !tbl_hit && !tbl_full && !clr;
        tbl_free   = dec_valid && !dec_make && !clr;
        // Repeated or unplaceable makes are swallowed; clr empties the table
        // so every decoded key on that byte is reported.
        emit       = dec_valid && (clr || !dec_make || (!tbl_hit && !tbl_full));
        ev_valid_d = emit;
        ev_code_d  = emit ? dec_code : ev_code_q;
        ev_make_d  = emit ? dec_make : ev_make_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q || (dec_valid && dec_make && !tbl_hit && tbl_full);
        end
    end

    // Decoder and event state registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= '0;
            ev_make_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_make_q  <= ev_make_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_key_table #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_table (
        .clk_i        (CLOCK_50),
        .rst_ni       (resetn),
        .clr_i        (clr),
        .alloc_i      (tbl_alloc),
        .free_i       (tbl_free),
        .code_i       (dec_code),
        .hit_o        (tbl_hit),
        .full_o       (tbl_full),
        .held_codes_o (held_codes),
        .held_valid_o (held_valid),
        .held_count_o (held_count)
    );

    assign ev_valid = ev_valid_q;
    assign ev_code  = ev_code_q;
    assign ev_make  = ev_make_q;
    assign overflow = overflow_q;

`ifdef PS2_TRACKER_HEX_EN
    Hexadecimal_To_Seven_Segment u_hex0 (
        .hex_number        (ev_code_q[3:0]),
        .seven_seg_display (HEX0)
    );
    Hexadecimal_To_Seven_Segment u_hex1 (
        .hex_number        (ev_code_q[7:4]),
        .seven_seg_display (HEX1)
    );
    Hexadecimal_To_Seven_Segment u_hex2 (
        .hex_number        ({3'b000, ev_code_q[8]}),
        .seven_seg_display (HEX2)
    );
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed, table-driven bench for ps2_key_tracker (default parameters).
module tb_ps2_key_tracker;

    logic        clk;
    logic        resetn;
    logic        clr;
    logic [7:0]  data;
    logic        strobe;
    logic        ev_valid;
    logic [8:0]  ev_code;
    logic        ev_make;
    logic [35:0] held_codes;
    logic [3:0]  held_valid;
    logic [2:0]  held_count;
    logic        overflow;
    logic [6:0]  hex0, hex1, hex2;

    logic        cap_ev;
    logic [8:0]  cap_code;
    logic        cap_make;

    int n_pass  = 0;
    int n_total = 0;

`ifdef PS2_TRACKER_HEX_EN
    localparam logic [6:0] HEX_ZERO = 7'h40;
    localparam logic [6:0] HEX_ONE  = 7'h79;
    localparam logic [6:0] HEX_C    = 7'h46;
`else
    localparam logic [6:0] HEX_ZERO = 7'h7F;
    localparam logic [6:0] HEX_ONE  = 7'h7F;
    localparam logic [6:0] HEX_C    = 7'h7F;
`endif

    ps2_key_tracker dut (
        .CLOCK_50        (clk),
        .resetn          (resetn),
        .clr             (clr),
        .ps2_key_data    (data),
        .ps2_key_pressed (strobe),
        .ev_valid        (ev_valid),
        .ev_code         (ev_code),
        .ev_make         (ev_make),
        .held_codes      (held_codes),
        .held_valid      (held_valid),
        .held_count      (held_count),
        .overflow        (overflow),
        .HEX0            (hex0),
        .HEX1            (hex1),
        .HEX2            (hex2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        clr;
        logic        exp_ev;
        logic [8:0]  exp_code;
        logic        exp_make;
        logic [3:0]  exp_valid;
        logic [2:0]  exp_count;
        logic        exp_ovf;
        logic [35:0] exp_codes;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [7:0] d, input logic c, input logic ev,
                                input logic [8:0] code, input logic mk_, input logic [3:0] v,
                                input logic [2:0] n, input logic ovf, input logic [35:0] codes);
        vec_t r;
        r.data = d; r.clr = c; r.exp_ev = ev; r.exp_code = code; r.exp_make = mk_;
        r.exp_valid = v; r.exp_count = n; r.exp_ovf = ovf; r.exp_codes = codes;
        return r;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One strobed byte; outputs captured in the cycle after the strobe edge.
    task automatic send_byte(input logic [7:0] b, input logic c);
        @(negedge clk);
        data   = b;
        strobe = 1'b1;
        clr    = c;
        @(negedge clk);
        strobe = 1'b0;
        clr    = 1'b0;
        cap_ev   = ev_valid;
        cap_code = ev_code;
        cap_make = ev_make;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; clr = 1'b0; strobe = 1'b0; data = 8'h00;

        // 1C make, typematic repeats, E0-extended make and break
        vq.push_back(mk(8'h1C, 0, 1, 9'h01C, 1, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'h1C, 0, 0, 9'h000, 0, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'h1C, 0, 0, 9'h000, 0, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'hE0, 0, 0, 9'h000, 0, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'h75, 0, 1, 9'h175, 1, 4'b0011, 3'd2, 0, {9'h0, 9'h0, 9'h175, 9'h01C}));
        vq.push_back(mk(8'hE0, 0, 0, 9'h000, 0, 4'b0011, 3'd2, 0, {9'h0, 9'h0, 9'h175, 9'h01C}));
        vq.push_back(mk(8'hF0, 0, 0, 9'h000, 0, 4'b0011, 3'd2, 0, {9'h0, 9'h0, 9'h175, 9'h01C}));
        vq.push_back(mk(8'h75, 0, 1, 9'h175, 0, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'hF0, 0, 0, 9'h000, 0, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h01C}));
        vq.push_back(mk(8'h1C, 0, 1, 9'h01C, 0, 4'b0000, 3'd0, 0, 36'h0));
        // break of an unheld key, discarded status byte
        vq.push_back(mk(8'hF0, 0, 0, 9'h000, 0, 4'b0000, 3'd0, 0, 36'h0));
        vq.push_back(mk(8'h33, 0, 1, 9'h033, 0, 4'b0000, 3'd0, 0, 36'h0));
        vq.push_back(mk(8'hFA, 0, 0, 9'h000, 0, 4'b0000, 3'd0, 0, 36'h0));
        // fill, overflow, free slot 1, refill slot 1
        vq.push_back(mk(8'h15, 0, 1, 9'h015, 1, 4'b0001, 3'd1, 0, {9'h0, 9'h0, 9'h0, 9'h015}));
        vq.push_back(mk(8'h1D, 0, 1, 9'h01D, 1, 4'b0011, 3'd2, 0, {9'h0, 9'h0, 9'h01D, 9'h015}));
        vq.push_back(mk(8'h24, 0, 1, 9'h024, 1, 4'b0111, 3'd3, 0, {9'h0, 9'h024, 9'h01D, 9'h015}));
        vq.push_back(mk(8'h2D, 0, 1, 9'h02D, 1, 4'b1111, 3'd4, 0, {9'h02D, 9'h024, 9'h01D, 9'h015}));
        vq.push_back(mk(8'h2C, 0, 0, 9'h000, 0, 4'b1111, 3'd4, 1, {9'h02D, 9'h024, 9'h01D, 9'h015}));
        vq.push_back(mk(8'h15, 0, 0, 9'h000, 0, 4'b1111, 3'd4, 1, {9'h02D, 9'h024, 9'h01D, 9'h015}));
        vq.push_back(mk(8'hF0, 0, 0, 9'h000, 0, 4'b1111, 3'd4, 1, {9'h02D, 9'h024, 9'h01D, 9'h015}));
        vq.push_back(mk(8'h1D, 0, 1, 9'h01D, 0, 4'b1101, 3'd3, 1, {9'h02D, 9'h024, 9'h0, 9'h015}));
        vq.push_back(mk(8'h2C, 0, 1, 9'h02C, 1, 4'b1111, 3'd4, 1, {9'h02D, 9'h024, 9'h02C, 9'h015}));
        // clr with a prefix byte: table emptied, prefix still decoded
        vq.push_back(mk(8'hF0, 1, 0, 9'h000, 0, 4'b0000, 3'd0, 0, 36'h0));
        vq.push_back(mk(8'h15, 0, 1, 9'h015, 0, 4'b0000, 3'd0, 0, 36'h0));

        // Reset values while resetn is low
        repeat (3) @(negedge clk);
        check("rst ev_valid", ev_valid, 0);
        check("rst ev_code", ev_code, 0);
        check("rst ev_make", ev_make, 0);
        check("rst held_valid", held_valid, 0);
        check("rst held_codes", held_codes, 0);
        check("rst held_count", held_count, 0);
        check("rst overflow", overflow, 0);
        check("rst hex", {hex2, hex1, hex0}, {HEX_ZERO, HEX_ZERO, HEX_ZERO});
        resetn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            send_byte(vq[i].data, vq[i].clr);
            check($sformatf("v%0d ev_valid", i), cap_ev, vq[i].exp_ev);
            if (vq[i].exp_ev) begin
                check($sformatf("v%0d ev_code", i), cap_code, vq[i].exp_code);
                check($sformatf("v%0d ev_make", i), cap_make, vq[i].exp_make);
            end
            check($sformatf("v%0d held_valid", i), held_valid, vq[i].exp_valid);
            check($sformatf("v%0d held_count", i), held_count, vq[i].exp_count);
            check($sformatf("v%0d overflow", i), overflow, vq[i].exp_ovf);
            check($sformatf("v%0d held_codes", i), held_codes, vq[i].exp_codes);
            @(negedge clk);
            check($sformatf("v%0d ev_pulse", i), ev_valid, 0);
        end

        // E0 then exactly TIMEOUT_CYC idle cycles: prefix is dropped
        send_byte(8'hE0, 1'b0);
        repeat (49999) @(negedge clk);
        send_byte(8'h1C, 1'b0);
        check("tmo ev_valid", cap_ev, 1);
        check("tmo ev_code", cap_code, 9'h01C);
        check("tmo ev_make", cap_make, 1);
        check("tmo held_codes", held_codes, {9'h0, 9'h0, 9'h0, 9'h01C});

        // Reset after F0 while 1C is held: prefix and table both forgotten
        send_byte(8'hF0, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid rst held_valid", held_valid, 0);
        check("mid rst held_count", held_count, 0);
        check("mid rst ev_code", ev_code, 0);
        check("mid rst overflow", overflow, 0);
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h1C, 1'b0);
        check("post rst ev_valid", cap_ev, 1);
        check("post rst ev_code", cap_code, 9'h01C);
        check("post rst ev_make", cap_make, 1);
        check("post rst held_count", held_count, 1);
        check("post rst hex", {hex2, hex1, hex0}, {HEX_ZERO, HEX_ONE, HEX_C});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
